// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared definitions for the timer arbiter.
//   - FSM state encoding (ST_IDLE / ST_COUNT) and its enum view
//   - default parameter values (NREQ_DEF, CW_DEF)
//   - rr_next(): round-robin winner search, used by rr_pick
package timer_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 28;

    // Index width sized for the largest supported requester count (8).
    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = 3;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_COUNT = ST_COUNT
    } state_e;

    // First set bit of req searching upward from (last+1) mod nreq, with wrap.
    // The loop runs from the farthest candidate down to the nearest so the
    // nearest set bit is the one left standing. Returns last if req is empty.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_NREQ-1:0] req,
        input logic [IDX_W-1:0]    last,
        input int                  nreq
    );
        int idx;
        rr_next = last;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(last) + k) % nreq;
                if (req[idx]) rr_next = idx[IDX_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in   NREQ    pending requests
//   last  in   IDX_W   index of the previous winner
//   valid out  1       any request pending
//   win   out  IDX_W   winning requester index (meaningful when valid)
module rr_pick
    import timer_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] win
);

    logic [MAX_NREQ-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
    end

    assign valid = |req;
    assign win   = rr_next(req_ext, last, NREQ);

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared delay counter handed out round-robin to NREQ
// requesters. The winner's delay is captured at grant; when the count
// reaches it, a one-cycle done pulse returns to that requester.
// Non-preemptive. All outputs are registered.
//   clk      in   1         system clock
//   rst_n    in   1         asynchronous active-low reset
//   req      in   NREQ      level requests, held until done
//   delay    in   NREQ*CW   per-requester delay, requester i at [i*CW +: CW]
//   gnt      out  NREQ      one-hot owner of the counter
//   done     out  NREQ      one-hot expiry pulse
//   busy     out  1         counter running
//   abort    in   1         cancel current count    (TIMER_ARB_ABORT_EN)
//   aborted  out  NREQ      one-hot cancel pulse     (TIMER_ARB_ABORT_EN)
// Optional feature macro: TIMER_ARB_ABORT_EN.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] delay,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy
`ifdef TIMER_ARB_ABORT_EN
    ,
    input  logic              abort,
    output logic [NREQ-1:0]   aborted
`endif
);

    logic [NREQ-1:0][CW-1:0] delay_a;
    assign delay_a = delay;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [CW-1:0]       limit_q, limit_d;
    logic [IDX_W-1:0]    last_q,  last_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [NREQ-1:0]     done_q,  done_d;
    logic                busy_q,  busy_d;
`ifdef TIMER_ARB_ABORT_EN
    logic [NREQ-1:0]     aborted_q, aborted_d;
`endif

    logic             pick_vld;
    logic [IDX_W-1:0] pick_win;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_vld),
        .win   (pick_win)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
`ifdef TIMER_ARB_ABORT_EN
        aborted_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    // Select by comparison rather than indexing so the
                    // fixed-width win index never over-addresses NREQ.
                    gnt_d = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_win == IDX_W'(i)) begin
                            gnt_d[i] = 1'b1;
                            limit_d  = delay_a[i];
                        end
                    end
                    last_d  = pick_win;
                    cnt_d   = '0;
                    state_d = S_COUNT;
                    busy_d  = 1'b1;
                end
            end
            S_COUNT: begin
`ifdef TIMER_ARB_ABORT_EN
                if (abort) begin
                    // Abort wins over a simultaneous expiry.
                    aborted_d = gnt_q;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else
`endif
                if (cnt_q == limit_q) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
`ifdef TIMER_ARB_ABORT_EN
            aborted_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef TIMER_ARB_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
`ifdef TIMER_ARB_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter (NREQ=4, CW=28). A table of request scenarios with
// hand-written grant orders is expanded into expected grant/done windows using
// the documented latency (grant at sample+1, done at grant+D+1, next grant one
// cycle later); a negedge monitor pops and compares them. Reset, delay-change
// and abort corners are hand-written sequences.
module tb_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 28;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*CW-1:0]   delay;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
`ifdef TIMER_ARB_ABORT_EN
    logic                 abort;
    logic [NREQ-1:0]      aborted;
`endif

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .delay   (delay),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
`ifdef TIMER_ARB_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0]       req;
        logic [3:0][27:0] dly;
        logic [3:0]       ngr;
        logic [4:0][1:0]  order;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r,
                                input int d0, input int d1, input int d2, input int d3,
                                input int n,
                                input int o0, input int o1, input int o2, input int o3, input int o4);
        vec_t v;
        v.req      = r;
        v.dly[0]   = 28'(d0);
        v.dly[1]   = 28'(d1);
        v.dly[2]   = 28'(d2);
        v.dly[3]   = 28'(d3);
        v.ngr      = 4'(n);
        v.order[0] = 2'(o0);
        v.order[1] = 2'(o1);
        v.order[2] = 2'(o2);
        v.order[3] = 2'(o3);
        v.order[4] = 2'(o4);
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] idx;
        int         gc;   // first cycle gnt is seen
        int         dc;   // cycle done is seen
    } exp_t;

    exp_t sb[$];
    logic mon_en = 1'b0;
    exp_t       m_e;
    logic [3:0] m_gnt, m_done;

    always @(negedge clk) begin
        if (mon_en) begin
            m_gnt  = '0;
            m_done = '0;
            if (sb.size() != 0) begin
                m_e = sb[0];
                if (cyc >= m_e.gc && cyc < m_e.dc) m_gnt  = 4'b0001 << m_e.idx;
                if (cyc == m_e.dc)                 m_done = 4'b0001 << m_e.idx;
            end
            chk("gnt",  32'(gnt),  32'(m_gnt));
            chk("done", 32'(done), 32'(m_done));
            chk("busy", 32'(busy), 32'(|m_gnt));
            if (sb.size() != 0 && cyc == sb[0].dc) void'(sb.pop_front());
        end
    end

    task automatic wait_sb();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int p, last_gc, d;
        @(negedge clk);
        req   = v.req;
        delay = v.dly;
        p       = cyc + 1;
        last_gc = p;
        for (int k = 0; k < int'(v.ngr); k++) begin
            d = int'(v.dly[v.order[k]]);
            sb.push_back('{idx: v.order[k], gc: p, dc: p + d + 1});
            last_gc = p;
            p = p + d + 2;
        end
        // Drop requests once the final expected grant has been taken.
        while (cyc < last_gc) @(negedge clk);
        req = '0;
        wait_sb();
    endtask

    vec_t vtab [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc;
        // Pointer starts at 3, so the first all-request grant goes to 0.
        vtab[0] = mk(4'b1111, 2, 2, 2, 2,   5, 0, 1, 2, 3, 0);
        vtab[1] = mk(4'b0100, 9, 9, 5, 9,   1, 2, 0, 0, 0, 0);
        vtab[2] = mk(4'b0001, 0, 7, 7, 7,   2, 0, 0, 0, 0, 0);
        vtab[3] = mk(4'b1010, 4, 1, 4, 7,   3, 1, 3, 1, 0, 0);
        vtab[4] = mk(4'b1001, 3, 0, 0, 4,   2, 3, 0, 0, 0, 0);
        vtab[5] = mk(4'b0110, 5, 0, 9, 5,   4, 1, 2, 1, 2, 0);

        rst_n = 1'b0;
        req   = '0;
        delay = '0;
`ifdef TIMER_ARB_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(gnt),  0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Reset in the middle of a long count: outputs clear without a clock.
        @(negedge clk);
        req   = 4'b0010;
        delay = '0;
        delay[1*CW +: CW] = 28'd100;
        repeat (5) @(negedge clk);
        chk("pre_rst_gnt",  32'(gnt),  32'h2);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt",  32'(gnt),  0);
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_done", 32'(done), 0);
        rst_n = 1'b1;
        req   = '0;

        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vtab[i]);

        // Delay captured at grant: later delay change and req drop are ignored.
        @(negedge clk);
        req   = 4'b0010;
        delay = '0;
        delay[1*CW +: CW] = 28'd3;
        gc = cyc + 1;
        sb.push_back('{idx: 2'd1, gc: gc, dc: gc + 4});
        while (cyc < gc) @(negedge clk);
        req = '0;
        delay[1*CW +: CW] = 28'd50;
        wait_sb();

`ifdef TIMER_ARB_ABORT_EN
        mon_en = 1'b0;
        @(negedge clk);
        req   = 4'b1000;
        delay = '0;
        delay[3*CW +: CW] = 28'd2;
        gc = cyc + 1;
        while (cyc < gc) @(negedge clk);
        req = '0;
        chk("ab_gnt", 32'(gnt), 32'h8);
        // Abort lands on the edge where cnt==limit.
        while (cyc < gc + 2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_pulse",  32'(aborted), 32'h8);
        chk("ab_done",   32'(done),    0);
        chk("ab_gnt0",   32'(gnt),     0);
        chk("ab_busy",   32'(busy),    0);
        @(negedge clk);
        chk("ab_pulse1", 32'(aborted), 0);
        chk("ab_done1",  32'(done),    0);
        // Abort while idle does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("ab_idle", 32'(aborted), 0);
        chk("ab_idle_gnt", 32'(gnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
